// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings
// and the default oversampling ratio.
package uart_pkg;

    localparam int TICK_PER_BIT_DEF = 16;
    localparam int FRAME_BITS       = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle line never looks like a start bit.
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_Clock) begin
        if (!i_reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an external oversampling strobe.
// Samples mid-bit, reports framing errors and waits out line breaks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_PER_BIT = TICK_PER_BIT_DEF
) (
    input  logic       i_Clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       sample_tick,
    input  logic       i_RX,
    output logic [7:0] o_data,
    output logic       o_RX_Done,
    output logic       o_RX_Active,
    output logic       o_frame_err
);

    localparam int CW = $clog2(TICK_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(TICK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_PER_BIT - 1);

    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_reset (i_reset),
        .d       (i_RX),
        .q       (rx_s)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_RX_Done   <= 1'b0;
            o_RX_Active <= 1'b0;
            o_frame_err <= 1'b0;
        end else if (!i_enable) begin
            o_RX_Done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_RX_Done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state       <= S_START;
                        cnt         <= '0;
                        idx         <= '0;
                        o_RX_Active <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        if (cnt == HALF) begin
                            cnt <= '0;
                            // Start bit gone high by mid-bit: treat as a glitch
                            if (rx_s) begin
                                state       <= S_IDLE;
                                o_RX_Active <= 1'b0;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        if (cnt == LAST) begin
                            cnt        <= '0;
                            shift[idx] <= rx_s;
                            if (idx == 3'd7) begin
                                state <= S_STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state       <= S_IDLE;
                                o_data      <= shift;
                                o_RX_Done   <= 1'b1;
                                o_RX_Active <= 1'b0;
                            end else begin
                                state       <= S_BREAK;
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before any new frame
                    if (rx_s) begin
                        state       <= S_IDLE;
                        o_RX_Active <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    idx         <= '0;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule
